// File: rtl/cam_pkg.sv
// Shared types for the dictionary CAM bank and its configuration-port arbiter.
// Contents: key width constant, cfg write record shared with cam_bank, and the
// update-arbiter FSM state encoding.
package cam_pkg;

    localparam int CAM_KEY_WIDTH = 96;

    // One configuration write as seen on the cam_bank cfg port.
    typedef struct packed {
        logic [31:0]              addr;
        logic [CAM_KEY_WIDTH-1:0] key;
        logic [31:0]              match_id;
        logic [7:0]               len;
        logic                     is_hbm;
    } cam_cfg_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_CLEAR = 2'd2
    } cam_upd_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request bit at or above ptr_i, wrapping.
// Purely combinational; zero latency.
// Ports: req_i request vector, ptr_i search start, gnt_o one-hot, idx_o index, vld_o any grant.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             vld_o
);

    // Walk offsets from farthest to nearest so the nearest requester at or
    // after the pointer is the last (winning) assignment.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_i) + k) % N]) begin
                gnt_o = N'(1) << ((int'(ptr_i) + k) % N);
                idx_o = IDX_W'((int'(ptr_i) + k) % N);
                vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cam_update_arbiter.sv
// Shares the cam_bank cfg write port among NUM_REQ updaters (round-robin) and sequences bulk clears.
// Latency: grant at edge N, cfg_valid from N+1; 2 cycles minimum per write; timeout drops a write.
// Ports: req_* requester side (req_ready combinational), cfg_* registered to cam_bank, clear_* / err_* status.
module cam_update_arbiter
    import cam_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int KEY_WIDTH   = CAM_KEY_WIDTH,  // must equal CAM_KEY_WIDTH (cam_bank key width)
    parameter int CAM_DEPTH   = 65536,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*32-1:0]          req_addr,
    input  logic [NUM_REQ*KEY_WIDTH-1:0]   req_key,
    input  logic [NUM_REQ*32-1:0]          req_match_id,
    input  logic [NUM_REQ*8-1:0]           req_len,
    input  logic [NUM_REQ-1:0]             req_is_hbm,
    input  logic                           clear_start,
    output logic                           clear_busy,
    output logic                           clear_done,
    output logic                           probe_quiesce,
    output logic                           cfg_valid,
    output logic [31:0]                    cfg_addr,
    output logic [KEY_WIDTH-1:0]           cfg_key,
    output logic [31:0]                    cfg_match_id,
    output logic [7:0]                     cfg_len,
    output logic                           cfg_is_hbm,
    input  logic                           cfg_rdy,
    output logic                           err_timeout,
    output logic [2:0]                     err_req_id
);

    localparam int IDX_W = $clog2(NUM_REQ);

    cam_upd_state_e     state_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   src_q;
    cam_cfg_t           cfg_q;
    logic               cfg_valid_q;
    logic [15:0]        tmo_cnt_q;
    logic [15:0]        tmo_cnt_d;
    logic               clear_busy_q;
    logic               clear_done_q;
    logic               err_timeout_q;
    logic [2:0]         err_req_id_q;

    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_vld;
    cam_cfg_t           req_pay;
    logic               tmo_hit;
    logic               clr_last;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .vld_o (gnt_vld)
    );

    // Payload of the requester that would win this cycle.
    always_comb begin
        req_pay          = '0;
        req_pay.addr     = req_addr[int'(gnt_idx)*32 +: 32];
        req_pay.key      = req_key[int'(gnt_idx)*KEY_WIDTH +: KEY_WIDTH];
        req_pay.match_id = req_match_id[int'(gnt_idx)*32 +: 32];
        req_pay.len      = req_len[int'(gnt_idx)*8 +: 8];
        req_pay.is_hbm   = req_is_hbm[gnt_idx];
    end

    // A pending clear_start in IDLE wins over requests, so no grant that cycle.
    assign req_ready = (state_q == ST_IDLE && !clear_start) ? gnt : '0;

    // tmo_cnt_q counts stalled cycles already seen; the write is dropped when
    // the current stalled cycle would bring the total to TIMEOUT_CYC.
    assign tmo_cnt_d = tmo_cnt_q + 16'd1;
    assign tmo_hit   = (tmo_cnt_d == 16'(TIMEOUT_CYC));
    // During a clear, cfg_q.addr doubles as the sweep address.
    assign clr_last  = (cfg_q.addr == 32'(CAM_DEPTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            src_q         <= '0;
            cfg_q         <= '0;
            cfg_valid_q   <= 1'b0;
            tmo_cnt_q     <= '0;
            clear_busy_q  <= 1'b0;
            clear_done_q  <= 1'b0;
            err_timeout_q <= 1'b0;
            err_req_id_q  <= '0;
        end else begin
            clear_done_q  <= 1'b0;
            err_timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (clear_start) begin
                        cfg_q        <= '0;
                        cfg_valid_q  <= 1'b1;
                        clear_busy_q <= 1'b1;
                        state_q      <= ST_CLEAR;
                    end else if (gnt_vld) begin
                        cfg_q       <= req_pay;
                        cfg_valid_q <= 1'b1;
                        src_q       <= gnt_idx;
                        rr_ptr_q    <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
                        tmo_cnt_q   <= '0;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (cfg_rdy) begin
                        cfg_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else if (tmo_hit) begin
                        cfg_valid_q   <= 1'b0;
                        err_timeout_q <= 1'b1;
                        err_req_id_q  <= 3'(src_q);
                        state_q       <= ST_IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_d;
                    end
                end
                ST_CLEAR: begin
                    if (cfg_rdy) begin
                        if (clr_last) begin
                            cfg_valid_q  <= 1'b0;
                            clear_busy_q <= 1'b0;
                            clear_done_q <= 1'b1;
                            state_q      <= ST_IDLE;
                        end else begin
                            cfg_q.addr <= cfg_q.addr + 32'd1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cfg_valid     = cfg_valid_q;
    assign cfg_addr      = cfg_q.addr;
    assign cfg_key       = cfg_q.key;
    assign cfg_match_id  = cfg_q.match_id;
    assign cfg_len       = cfg_q.len;
    assign cfg_is_hbm    = cfg_q.is_hbm;
    assign clear_busy    = clear_busy_q;
    assign probe_quiesce = clear_busy_q;
    assign clear_done    = clear_done_q;
    assign err_timeout   = err_timeout_q;
    assign err_req_id    = err_req_id_q;

endmodule

// File: doc/cam_update_arbiter.md
Name: cam_update_arbiter

Overview:
- Shares the single configuration write port of the dictionary CAM bank among NUM_REQ update requesters (dictionary learner, host loader, eviction engine, spare).
- Grants requesters round-robin and holds each write on the cfg port until the bank accepts it. A per-write timeout keeps a stalled HBM path from blocking the port.
- Also sequences a bulk clear of the on-chip CAM entries, with probe quiesce.
- Sits between the update sources and cam_bank cfg_*.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- KEY_WIDTH, 96, hash key width; must match cam_bank
- CAM_DEPTH, 65536, on-chip entries swept by a clear
- TIMEOUT_CYC, 255, max cycles cfg_valid may wait for cfg_rdy (1..65535)

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester write request
- req_ready  out  NUM_REQ  per-requester accept; at most one bit set
- req_addr  in  NUM_REQ*32  entry address, requester i at [32i+:32]
- req_key  in  NUM_REQ*KEY_WIDTH  key hash
- req_match_id  in  NUM_REQ*32  dictionary ID
- req_len  in  NUM_REQ*8  original length
- req_is_hbm  in  NUM_REQ  1 = HBM target, 0 = on-chip
- clear_start  in  1  pulse: start bulk clear
- clear_busy  out  1  clear in progress
- clear_done  out  1  one-cycle pulse at clear completion
- probe_quiesce  out  1  high while clearing; upstream must hold probe_valid low
- cfg_valid  out  1  to cam_bank
- cfg_addr  out  32  to cam_bank
- cfg_key  out  KEY_WIDTH  to cam_bank
- cfg_match_id  out  32  to cam_bank
- cfg_len  out  8  to cam_bank
- cfg_is_hbm  out  1  to cam_bank
- cfg_rdy  in  1  from cam_bank
- err_timeout  out  1  one-cycle pulse: write dropped on timeout
- err_req_id  out  3  requester index of the dropped write; held until next timeout

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; rr_ptr=0; counters 0. Reset mid-operation aborts any write or clear immediately with no done/err pulse.
- FSM states: IDLE, ISSUE, CLEAR.
- IDLE, priority:
  - clear_start=1: go to CLEAR with clr_addr=0. This takes precedence over pending requests in the same cycle; no req_ready is given.
  - else any req_valid: grant g = first set bit searching from rr_ptr upward with wrap. req_ready[g]=1 combinationally in the same cycle. On that edge, latch the payload into cfg_* regs, set rr_ptr=(g+1) mod NUM_REQ, go to ISSUE.
  - req_ready is 0 in every other state.
- ISSUE:
  - cfg_valid=1 and cfg_* stable.
  - cfg_rdy=1: the write completes this cycle; cfg_valid drops next cycle; return to IDLE.
  - Latency: req handshake at edge N, cfg_valid high from N+1. Minimum 2 cycles per write, so peak throughput is 1 write per 2 cycles.
  - Timeout counter starts at 0 on ISSUE entry and increments each cycle cfg_rdy=0. On reaching TIMEOUT_CYC: pulse err_timeout, set err_req_id=g, drop cfg_valid, return to IDLE. The write is lost; the requester is not re-granted automatically.
  - cfg_rdy arriving in the same cycle the count reaches TIMEOUT_CYC counts as success, with no error.
  - clear_start during ISSUE is ignored; it is not queued.
- CLEAR:
  - clear_busy=1 and probe_quiesce=1 from the cycle after entry.
  - cfg_valid=1, cfg_addr=clr_addr, cfg_key=0, cfg_match_id=0, cfg_len=0, cfg_is_hbm=0.
  - Each cycle with cfg_rdy=1, clr_addr increments. No timeout applies in CLEAR.
  - After the write with clr_addr=CAM_DEPTH-1 is accepted: clear_done pulses the next cycle, clear_busy and probe_quiesce fall that same cycle, return to IDLE.
  - clr_addr is 32-bit; it never wraps because CAM_DEPTH ≤ 2^31.
  - clear_start during CLEAR is ignored.
- Requesters must hold req_valid and payload stable until req_ready. Dropping req_valid earlier is legal, and no grant is then given.
- cfg_* are registered outputs with no combinational path from req_* to cfg_*.

Decomposition:
- Package cam_pkg:
  - typedef cam_cfg_t {addr[31:0], key[KEY_WIDTH-1:0], match_id[31:0], len[7:0], is_hbm}, shared with cam_bank.
  - FSM state enum.
  - Constant CAM_KEY_WIDTH=96.
- One sub-module: rr_arbiter (NUM_REQ-wide request vector + pointer → one-hot grant + index), reusable elsewhere.

Test Plan:
- Each case checks the required response for the given stimulus.
- Single request: req_valid=4'b0010, addr=0x100, key=96'hABC, id=7, cfg_rdy=1 → req_ready=4'b0010 at cycle N; cfg_valid=1 at N+1 with cfg_addr=0x100, id=7; cfg_valid=0 at N+2.
- Round robin: req_valid=4'b1111 held, cfg_rdy=1 → grants in order 0,1,2,3,0 at one grant per 2 cycles.
- Timeout: TIMEOUT_CYC=4, requester 2 granted, cfg_rdy=0 → err_timeout pulses 4 cycles after cfg_valid rises, err_req_id=2, FSM returns to IDLE. Repeat with cfg_rdy=1 on exactly cycle 4 → no error.
- Clear: CAM_DEPTH=8, clear_start with req_valid=4'b0001 in the same cycle → 8 writes addr 0..7 with key 0 and is_hbm=0; clear_done one cycle after the last accepted write; requester 0 granted the cycle after that.
- Clear under backpressure: cfg_rdy toggling 1,0,1,0 → each address is issued until accepted, none skipped, no timeout. Assert rst_n low at addr 3 → all outputs 0, no clear_done.
- Ignored start: clear_start pulsed during ISSUE → no clear occurs, and clear_busy stays 0.
